// File: rtl/interval_timer_bank_if.sv
// interval_timer_bank_if: command and status bundle for the timer bank.
// The controller drives start/stop/mode/limit and watches busy/done/count.
interface interval_timer_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 28
);
  logic [CHANNELS-1:0]       start;
  logic [CHANNELS-1:0]       stop;
  logic [CHANNELS-1:0]       periodic;
  logic [CHANNELS*WIDTH-1:0] limit;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       done;
  logic [CHANNELS*WIDTH-1:0] count;

  modport master (
    output start, stop, periodic, limit,
    input  busy, done, count
  );

  modport slave (
    input  start, stop, periodic, limit,
    output busy, done, count
  );
endinterface

// File: rtl/interval_timer_bank.sv
// interval_timer_bank: CHANNELS programmable interval timers
// driven by one shared free-running prescaler.
module interval_timer_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 28,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  interval_timer_bank_if.slave bus
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [PW-1:0] pre;
  logic          tick;

  // With PRESCALE=1 pre stays 0 and tick is constantly high.
  always_ff @(posedge clk) begin
    if (rst || pre == PMAX) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign tick = (pre == PMAX);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [0:0]       st;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] lim_in;
    logic             mode;
    logic             dn;

    assign lim_in = bus.limit[i*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= IDLE;
        cnt  <= '0;
        lim  <= '0;
        mode <= 1'b0;
        dn   <= 1'b0;
      end else begin
        dn <= 1'b0;
        if (st == IDLE) begin
          if (bus.start[i] && !bus.stop[i]) begin
            st   <= RUN;
            cnt  <= '0;
            lim  <= lim_in;
            mode <= bus.periodic[i];
          end
        end else begin
          priority case (1'b1)
            bus.stop[i]: begin
              st  <= IDLE;
              cnt <= '0;
            end
            bus.start[i]: begin
              cnt  <= '0;
              lim  <= lim_in;
              mode <= bus.periodic[i];
            end
            (tick && cnt == lim): begin
              dn  <= 1'b1;
              cnt <= '0;
              if (!mode) st <= IDLE;
            end
            tick: begin
              cnt <= cnt + WIDTH'(1);
            end
            default: begin
            end
          endcase
        end
      end
    end

    assign bus.busy[i] = (st == RUN);
    assign bus.done[i] = dn;
    assign bus.count[i*WIDTH +: WIDTH] = cnt;
  end

endmodule
